// File: rtl/dcache_flush_mon.sv
// rtl/dcache_flush_mon.sv - data-cache flush engine with access-statistics monitor
// Walks every set, writes back valid dirty lines, marks them clean; counts hits/misses/write-backs.
module dcache_flush_mon #(
   parameter int SETS   = 32,
   parameter int IDX_W  = 5,
   parameter int TAG_W  = 22,
   parameter int LINE_W = 256,
   parameter int OFF_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   output logic                flush_busy_o,
   output logic                flush_done_o,
   output logic [IDX_W-1:0]    tag_addr_o,
   input  logic [TAG_W+1:0]    tag_rdata_i,
   input  logic [LINE_W-1:0]   data_rdata_i,
   output logic                tag_we_o,
   output logic [TAG_W+1:0]    tag_wdata_o,
   output logic                mem_enable_o,
   output logic                mem_write_o,
   output logic [31:0]         mem_addr_o,
   output logic [LINE_W-1:0]   mem_data_o,
   input  logic                mem_ack_i,
   input  logic                acc_rd_i,
   input  logic                acc_wr_i,
   input  logic                stall_i,
   input  logic                miss_start_i,
   input  logic                victim_dirty_i,
   input  logic                cnt_clr_i,
   output logic [CNT_W-1:0]    cnt_rd_hit_o,
   output logic [CNT_W-1:0]    cnt_rd_miss_o,
   output logic [CNT_W-1:0]    cnt_wr_hit_o,
   output logic [CNT_W-1:0]    cnt_wr_miss_o,
   output logic [CNT_W-1:0]    cnt_wb_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SCAN  = 3'd1;
   localparam logic [2:0] S_WB    = 3'd2;
   localparam logic [2:0] S_CLEAN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  wb_tag;
   logic [LINE_W-1:0] wb_data;
   logic              last_set;
   logic              line_dirty;
   logic              pend;

   assign last_set   = (idx == IDX_W'(SETS - 1));
   assign line_dirty = tag_rdata_i[TAG_W+1] & tag_rdata_i[TAG_W];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         idx     <= '0;
         wb_tag  <= '0;
         wb_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (flush_i) begin
                  idx   <= '0;
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (line_dirty) begin
                  wb_tag  <= tag_rdata_i[TAG_W-1:0];
                  wb_data <= data_rdata_i;
                  state   <= S_WB;
               end else if (last_set) begin
                  state <= S_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_WB: begin
               if (mem_ack_i) state <= S_CLEAN;
            end
            S_CLEAN: begin
               if (last_set) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= S_SCAN;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign flush_busy_o = (state != S_IDLE);
   assign flush_done_o = (state == S_DONE);
   assign tag_addr_o   = idx;
   assign tag_we_o     = (state == S_CLEAN);
   // Write value is gated so the tag bus idles at zero rather than showing a stale tag.
   assign tag_wdata_o  = tag_we_o ? {1'b1, 1'b0, wb_tag} : '0;
   assign mem_enable_o = (state == S_WB);
   assign mem_write_o  = (state == S_WB);
   assign mem_addr_o   = {wb_tag, idx, {OFF_W{1'b0}}};
   assign mem_data_o   = wb_data;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // pend marks an outstanding miss so its completing (unstalled) cycle is not scored as a hit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend          <= 1'b0;
         cnt_rd_hit_o  <= '0;
         cnt_rd_miss_o <= '0;
         cnt_wr_hit_o  <= '0;
         cnt_wr_miss_o <= '0;
         cnt_wb_o      <= '0;
      end else begin
         if (miss_start_i)
            pend <= 1'b1;
         else if (!stall_i)
            pend <= 1'b0;

         if (cnt_clr_i) begin
            cnt_rd_hit_o  <= '0;
            cnt_rd_miss_o <= '0;
            cnt_wr_hit_o  <= '0;
            cnt_wr_miss_o <= '0;
            cnt_wb_o      <= '0;
         end else if (miss_start_i) begin
            if (acc_rd_i)
               cnt_rd_miss_o <= sat_inc(cnt_rd_miss_o);
            else if (acc_wr_i)
               cnt_wr_miss_o <= sat_inc(cnt_wr_miss_o);
            if (victim_dirty_i)
               cnt_wb_o <= sat_inc(cnt_wb_o);
         end else if (!stall_i && !pend) begin
            if (acc_rd_i)
               cnt_rd_hit_o <= sat_inc(cnt_rd_hit_o);
            else if (acc_wr_i)
               cnt_wr_hit_o <= sat_inc(cnt_wr_hit_o);
         end
      end
   end

endmodule

// File: tb/tb_dcache_flush_mon.sv
// tb/tb_dcache_flush_mon.sv - self-checking bench for dcache_flush_mon
// Cache SRAM and memory are modelled here; expectations come from a set-list and event-count model.
module tb_dcache_flush_mon;
   localparam int SETS = 32, IDX_W = 5, TAG_W = 22, LINE_W = 256, OFF_W = 5, CNT_W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, flush = 1'b0, mem_ack = 1'b0;
   logic acc_rd = 1'b0, acc_wr = 1'b0, stall = 1'b0, miss_start = 1'b0, victim = 1'b0, cnt_clr = 1'b0;
   logic busy, done, tag_we, mem_en, mem_wr;
   logic [IDX_W-1:0]  tag_addr;
   logic [TAG_W+1:0]  tag_rdata, tag_wdata;
   logic [LINE_W-1:0] data_rdata, mem_data;
   logic [31:0]       mem_addr;
   logic [CNT_W-1:0]  c_rh, c_rm, c_wh, c_wm, c_wb;

   logic b4, d4, twe4, me4, mw4;
   logic [IDX_W-1:0]  ta4;
   logic [TAG_W+1:0]  twd4;
   logic [31:0]       ma4;
   logic [LINE_W-1:0] md4;
   logic [3:0]        c4_rh, c4_rm, c4_wh, c4_wm, c4_wb;

   logic [TAG_W+1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] data_mem [SETS];
   assign tag_rdata  = tag_mem[tag_addr];
   assign data_rdata = data_mem[tag_addr];

   dcache_flush_mon #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_busy_o(busy), .flush_done_o(done),
      .tag_addr_o(tag_addr), .tag_rdata_i(tag_rdata), .data_rdata_i(data_rdata),
      .tag_we_o(tag_we), .tag_wdata_o(tag_wdata), .mem_enable_o(mem_en), .mem_write_o(mem_wr),
      .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_ack_i(mem_ack),
      .acc_rd_i(acc_rd), .acc_wr_i(acc_wr), .stall_i(stall), .miss_start_i(miss_start),
      .victim_dirty_i(victim), .cnt_clr_i(cnt_clr),
      .cnt_rd_hit_o(c_rh), .cnt_rd_miss_o(c_rm), .cnt_wr_hit_o(c_wh), .cnt_wr_miss_o(c_wm), .cnt_wb_o(c_wb));

   dcache_flush_mon #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .OFF_W(OFF_W), .CNT_W(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_busy_o(b4), .flush_done_o(d4),
      .tag_addr_o(ta4), .tag_rdata_i(tag_rdata), .data_rdata_i(data_rdata),
      .tag_we_o(twe4), .tag_wdata_o(twd4), .mem_enable_o(me4), .mem_write_o(mw4),
      .mem_addr_o(ma4), .mem_data_o(md4), .mem_ack_i(mem_ack),
      .acc_rd_i(acc_rd), .acc_wr_i(acc_wr), .stall_i(stall), .miss_start_i(miss_start),
      .victim_dirty_i(victim), .cnt_clr_i(cnt_clr),
      .cnt_rd_hit_o(c4_rh), .cnt_rd_miss_o(c4_rm), .cnt_wr_hit_o(c4_wh), .cnt_wr_miss_o(c4_wm), .cnt_wb_o(c4_wb));

   int total = 0, bad = 0;
   int lat = 1, wb_cyc = 0, en_cycles = 0, wr_bad = 0;
   logic [31:0]       prev_addr;
   logic [LINE_W-1:0] prev_data;
   logic [31:0]       wa_q[$];
   logic [LINE_W-1:0] wd_q[$];
   logic [TAG_W+1:0]  tw_q[$];
   logic [IDX_W-1:0]  ti_q[$];

   // Memory responder and tag SRAM write port, acting just after each active edge.
   always @(posedge clk) begin
      #1;
      if (mem_en) begin
         en_cycles++;
         wb_cyc++;
         if (!mem_wr) wr_bad++;
         if (wb_cyc > 1 && (mem_addr !== prev_addr || mem_data !== prev_data)) wr_bad++;
         prev_addr = mem_addr;
         prev_data = mem_data;
         if (wb_cyc == lat) begin
            mem_ack = 1'b1;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_data);
         end else begin
            mem_ack = 1'b0;
         end
      end else begin
         wb_cyc  = 0;
         mem_ack = 1'b0;
      end
      if (tag_we) begin
         tw_q.push_back(tag_wdata);
         ti_q.push_back(tag_addr);
         tag_mem[tag_addr] = tag_wdata;
      end
   end

   task automatic fill_cache(input int mode);
      for (int s = 0; s < SETS; s++) begin
         tag_mem[s]  = {1'($urandom), (mode == 1) ? 1'($urandom) : 1'b0, 22'($urandom)};
         data_mem[s] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if (mode == 2) tag_mem[s] = '0;
      end
   endtask

   task automatic run_flush(input int l, input string nm, output int t_out);
      logic [31:0]       ea[$];
      logic [LINE_W-1:0] ed[$];
      logic [TAG_W+1:0]  et[$];
      logic [IDX_W-1:0]  ei[$];
      int exp_t, t, busy_bad;
      bit seen;
      lat = l; en_cycles = 0; wr_bad = 0; busy_bad = 0;
      wa_q.delete(); wd_q.delete(); tw_q.delete(); ti_q.delete();
      exp_t = SETS + 1;
      for (int s = 0; s < SETS; s++) begin
         if (tag_mem[s][TAG_W+1] && tag_mem[s][TAG_W]) begin
            ea.push_back({tag_mem[s][TAG_W-1:0], IDX_W'(s), OFF_W'(0)});
            ed.push_back(data_mem[s]);
            et.push_back({2'b10, tag_mem[s][TAG_W-1:0]});
            ei.push_back(IDX_W'(s));
            exp_t += l + 1;
         end
      end
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      total++;
      if (!(busy === 1'b1 && tag_addr === '0)) begin
         bad++; $display("FAIL %s first_scan: busy=%b idx=%0d required busy=1 idx=0", nm, busy, tag_addr);
      end
      t = 1; seen = 0;
      while (t < 3000) begin
         if (done === 1'b1) begin seen = 1; break; end
         if (busy !== 1'b1) busy_bad++;
         @(negedge clk); t++;
      end
      t_out = t;
      total++;
      if (!seen || t != exp_t) begin
         bad++; $display("FAIL %s done_time: got %0d (seen=%0d) required %0d", nm, t, seen, exp_t);
      end
      total++;
      if (busy_bad != 0 || busy !== 1'b1) begin
         bad++; $display("FAIL %s busy_span: %0d low cycles, busy at done=%b required 0 and 1", nm, busy_bad, busy);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL %s after_done: busy=%b done=%b required 0 0", nm, busy, done);
      end
      total++;
      if (en_cycles != l * ea.size() || wr_bad != 0) begin
         bad++; $display("FAIL %s mem_req: enable cycles=%0d proto errs=%0d required %0d and 0", nm, en_cycles, wr_bad, l * ea.size());
      end
      total++;
      if (wa_q.size() != ea.size() || tw_q.size() != ea.size()) begin
         bad++; $display("FAIL %s write_count: mem=%0d tag=%0d required %0d", nm, wa_q.size(), tw_q.size(), ea.size());
      end else begin
         for (int i = 0; i < ea.size(); i++) begin
            total++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i] || tw_q[i] !== et[i] || ti_q[i] !== ei[i]) begin
               bad++; $display("FAIL %s write%0d: addr=%h tag=%h@%0d required addr=%h tag=%h@%0d", nm, i, wa_q[i], tw_q[i], ti_q[i], ea[i], et[i], ei[i]);
            end
         end
      end
   endtask

   int m_rh, m_rm, m_wh, m_wm, m_wb;

   task automatic do_idle(input int n);
      acc_rd = 0; acc_wr = 0; stall = 0; miss_start = 0; victim = 0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_hit(input bit rd, input bit wr);
      acc_rd = rd; acc_wr = wr; stall = 0; miss_start = 0; victim = 0;
      @(negedge clk);
      acc_rd = 0; acc_wr = 0;
      if (rd) m_rh++; else if (wr) m_wh++;
   endtask

   task automatic do_miss(input bit rd, input bit wr, input bit vd, input int len);
      acc_rd = rd; acc_wr = wr; stall = 1; miss_start = 1; victim = vd;
      @(negedge clk);
      miss_start = 0; victim = 0;
      for (int i = 1; i < len; i++) @(negedge clk);
      stall = 0;
      @(negedge clk);
      acc_rd = 0; acc_wr = 0;
      if (rd) m_rm++; else if (wr) m_wm++;
      if (vd) m_wb++;
   endtask

   task automatic clear_counts();
      cnt_clr = 1; @(negedge clk); cnt_clr = 0;
      m_rh = 0; m_rm = 0; m_wh = 0; m_wm = 0; m_wb = 0;
   endtask

   function automatic int sat4(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic check_counts(input string nm);
      total++;
      if (c_rh !== CNT_W'(m_rh) || c_rm !== CNT_W'(m_rm) || c_wh !== CNT_W'(m_wh) || c_wm !== CNT_W'(m_wm) || c_wb !== CNT_W'(m_wb)) begin
         bad++; $display("FAIL %s counts: rh=%0d rm=%0d wh=%0d wm=%0d wb=%0d required %0d %0d %0d %0d %0d",
                         nm, c_rh, c_rm, c_wh, c_wm, c_wb, m_rh, m_rm, m_wh, m_wm, m_wb);
      end
      total++;
      if (c4_rh !== 4'(sat4(m_rh)) || c4_rm !== 4'(sat4(m_rm)) || c4_wh !== 4'(sat4(m_wh)) || c4_wm !== 4'(sat4(m_wm)) || c4_wb !== 4'(sat4(m_wb))) begin
         bad++; $display("FAIL %s counts4: rh=%0d rm=%0d wh=%0d wm=%0d wb=%0d required %0d %0d %0d %0d %0d",
                         nm, c4_rh, c4_rm, c4_wh, c4_wm, c4_wb, sat4(m_rh), sat4(m_rm), sat4(m_wh), sat4(m_wm), sat4(m_wb));
      end
   endtask

   task automatic test_reset();
      fill_cache(1);
      rst = 1;
      for (int i = 0; i < 4; i++) begin
         flush = 1'($urandom); acc_rd = 1'($urandom); acc_wr = 1'($urandom); stall = 1'($urandom);
         miss_start = 1'($urandom); victim = 1'($urandom); cnt_clr = 1'($urandom);
         @(negedge clk);
      end
      total++;
      if ({busy, done, tag_we, mem_en, mem_wr} !== 5'b0 || tag_addr !== '0 || tag_wdata !== '0) begin
         bad++; $display("FAIL reset_ctrl: busy=%b done=%b we=%b en=%b wr=%b idx=%0d twd=%h required all 0", busy, done, tag_we, mem_en, mem_wr, tag_addr, tag_wdata);
      end
      total++;
      if (mem_addr !== '0 || mem_data !== '0) begin
         bad++; $display("FAIL reset_mem: addr=%h data=%h required 0", mem_addr, mem_data);
      end
      total++;
      if ({c_rh, c_rm, c_wh, c_wm, c_wb} !== '0) begin
         bad++; $display("FAIL reset_cnt: rh=%0d rm=%0d wh=%0d wm=%0d wb=%0d required 0", c_rh, c_rm, c_wh, c_wm, c_wb);
      end
      flush = 0; cnt_clr = 0;
      do_idle(1);
      rst = 0;
      do_idle(1);
   endtask

   task automatic test_flush_clean();
      int t;
      fill_cache(2);
      run_flush(1, "all_invalid", t);
      total++;
      if (t != 33) begin bad++; $display("FAIL all_invalid_33: done at %0d required 33", t); end
      fill_cache(0);
      run_flush(3, "all_clean", t);
   endtask

   task automatic test_single_dirty();
      int t;
      fill_cache(2);
      tag_mem[3]  = {2'b11, 22'h000001};
      data_mem[3] = {32{8'hA5}};
      run_flush(11, "set3", t);
      total++;
      if (t != 45 || wa_q.size() != 1) begin
         bad++; $display("FAIL set3_fixed_time: done at %0d writes=%0d required 45 and 1", t, wa_q.size());
      end else begin
         total++;
         if (wa_q[0] !== 32'h0000_0460 || wd_q[0] !== {32{8'hA5}} || tw_q[0] !== {2'b10, 22'h000001}) begin
            bad++; $display("FAIL set3_fixed_vals: addr=%h tag=%h required 00000460 %h", wa_q[0], tw_q[0], {2'b10, 22'h000001});
         end
      end
   endtask

   task automatic test_back_to_back();
      int t;
      fill_cache(0);
      tag_mem[0]  = {2'b11, 22'h2ABCDE};
      tag_mem[31] = {2'b11, 22'h0F0F0F};
      run_flush(2, "sets0_31", t);
   endtask

   task automatic test_random_flush();
      int t;
      for (int r = 0; r < 3; r++) begin
         fill_cache(1);
         run_flush(int'($urandom_range(1, 6)), "random", t);
      end
   endtask

   task automatic test_access_trace();
      clear_counts();
      do_miss(1, 0, 0, 10);
      do_hit(1, 0);
      do_miss(0, 1, 1, 4);
      do_hit(0, 1);
      do_idle(1);
      check_counts("trace");
      total++;
      if (c_rm !== 1 || c_rh !== 1 || c_wm !== 1 || c_wh !== 1 || c_wb !== 1) begin
         bad++; $display("FAIL trace_fixed: rm=%0d rh=%0d wm=%0d wh=%0d wb=%0d required 1 each", c_rm, c_rh, c_wm, c_wh, c_wb);
      end
   endtask

   task automatic test_random_monitor();
      clear_counts();
      for (int e = 0; e < 80; e++) begin
         case ($urandom_range(0, 2))
            0: do_idle(1);
            1: do_hit(1'($urandom), 1'($urandom));
            default: do_miss(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(1, 5)));
         endcase
      end
      do_idle(1);
      check_counts("random_mon");
   endtask

   task automatic test_saturation();
      clear_counts();
      for (int i = 0; i < 20; i++) do_hit(1, 0);
      check_counts("sat20");
      total++;
      if (c4_rh !== 4'd15) begin bad++; $display("FAIL sat_fixed: cnt4=%0d required 15", c4_rh); end
      acc_rd = 1; cnt_clr = 1; @(negedge clk);
      acc_rd = 0; cnt_clr = 0;
      m_rh = 0; m_rm = 0; m_wh = 0; m_wm = 0; m_wb = 0;
      check_counts("clr_beats_hit");
   endtask

   task automatic test_reset_mid_wb();
      int t, w;
      fill_cache(2);
      tag_mem[3]  = {2'b11, 22'h000001};
      data_mem[3] = {32{8'hA5}};
      lat = 100;
      @(negedge clk); flush = 1;
      @(negedge clk); flush = 0;
      w = 0;
      while (mem_en !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      total++;
      if (mem_en !== 1'b1) begin bad++; $display("FAIL midwb_reach: enable=%b required 1", mem_en); end
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || mem_en !== 1'b0) begin
         bad++; $display("FAIL midwb_abort: busy=%b enable=%b required 0 0", busy, mem_en);
      end
      rst = 0;
      do_idle(1);
      run_flush(5, "restart", t);
      total++;
      if (t != 39) begin bad++; $display("FAIL restart_time: done at %0d required 39", t); end
   endtask

   initial begin
      for (int s = 0; s < SETS; s++) begin tag_mem[s] = '0; data_mem[s] = '0; end
      test_reset();
      test_flush_clean();
      test_single_dirty();
      test_back_to_back();
      test_random_flush();
      test_access_trace();
      test_random_monitor();
      test_saturation();
      test_reset_mid_wb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
